spi_slave_xcvr: RTL and testbench

Full-duplex SPI slave (mode 0, MSB first) that sits at the far end of the SPI link driven by `spi_master`. It oversamples `sclk`/`cs`/`mosi` on the system clock and shifts in one received word per frame. In the same frame it shifts out a word on `miso`, taken from a one-entry transmit holding buffer. Received words are presented to local logic as single-cycle strobes.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_pin_sync.sv | 33 +++
 rtl/spi_slave_xcvr.sv | 163 ++++++++++++++++
 tb/tb_spi_slave_xcvr.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave transceiver: default word width,
// bit-counter width and the frame state encoding.
package spi_pkg;

  localparam int SPI_WIDTH = 12;
  localparam int SPI_CNT_W = $clog2(SPI_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } spi_slv_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// N-stage synchronizer for one asynchronous pin, followed by an edge-detect
// register producing single-cycle rise/fall pulses on the synced level.
module spi_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchronizer chain and remember the last synced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_xcvr.sv
// Full-duplex SPI mode-0 slave, MSB first. Pins are oversampled on clk; one
// word is received and one word (from a one-entry holding buffer) is returned
// per chip-select frame.
module spi_slave_xcvr
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_abort,
  output logic             tx_underrun
);

  localparam int CNT_W    = $clog2(WIDTH + 1);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'(WIDTH - 1);

  logic csLvl, csRise, csFall;
  logic sclkRise, sclkFall, unused_sclkLvl;
  logic mosiLvl, unused_mosiRise, unused_mosiFall;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uCsSync (
    .clk(clk), .reset(reset), .pin_i(cs),
    .level_o(csLvl), .rise_o(csRise), .fall_o(csFall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSclkSync (
    .clk(clk), .reset(reset), .pin_i(sclk),
    .level_o(unused_sclkLvl), .rise_o(sclkRise), .fall_o(sclkFall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uMosiSync (
    .clk(clk), .reset(reset), .pin_i(mosi),
    .level_o(mosiLvl), .rise_o(unused_mosiRise), .fall_o(unused_mosiFall)
  );

  spi_slv_state_t       state_q, state_d;
  logic [CNT_W-1:0]     bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0]     rxShift_q, rxShift_d;
  logic [WIDTH-1:0]     txShift_q, txShift_d;
  logic [WIDTH-1:0]     txBuf_q, txBuf_d;
  logic                 txBufFull_q, txBufFull_d;
  logic [WIDTH-1:0]     rxData_q, rxData_d;
  logic                 rxValid_q, rxValid_d;
  logic                 rxAbort_q, rxAbort_d;
  logic                 underrun_q, underrun_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 armed_q, armed_d;

  // State and datapath registers; everything returns to the idle, empty-buffer condition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      rxShift_q   <= '0;
      txShift_q   <= '0;
      txBuf_q     <= '0;
      txBufFull_q <= 1'b0;
      rxData_q    <= '0;
      rxValid_q   <= 1'b0;
      rxAbort_q   <= 1'b0;
      underrun_q  <= 1'b0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      rxShift_q   <= rxShift_d;
      txShift_q   <= txShift_d;
      txBuf_q     <= txBuf_d;
      txBufFull_q <= txBufFull_d;
      rxData_q    <= rxData_d;
      rxValid_q   <= rxValid_d;
      rxAbort_q   <= rxAbort_d;
      underrun_q  <= underrun_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

  // Frame sequencing, shifting and holding-buffer management. The settle counter
  // keeps the reset-valued synchronizer contents from faking a cs edge, so a
  // frame already running at reset release is skipped until cs is seen high.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    rxShift_d   = rxShift_q;
    txShift_d   = txShift_q;
    txBuf_d     = txBuf_q;
    txBufFull_d = txBufFull_q;
    rxData_d    = rxData_q;
    rxValid_d   = 1'b0;
    rxAbort_d   = 1'b0;
    underrun_d  = 1'b0;
    settle_d    = (settle_q == SETTLE_DONE) ? settle_q : settle_q + SETTLE_W'(1);
    armed_d     = armed_q | ((settle_q == SETTLE_DONE) & csLvl);

    case (state_q)
      IDLE: begin
        if (armed_q && csFall) begin
          state_d   = SHIFT;
          bitCnt_d  = '0;
          rxShift_d = '0;
          if (txBufFull_q) begin
            txShift_d   = txBuf_q;
            txBufFull_d = 1'b0;
          end else begin
            txShift_d  = '0;
            underrun_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (csRise) begin
          state_d   = IDLE;
          rxAbort_d = 1'b1;
        end else if (sclkRise) begin
          rxShift_d = {rxShift_q[WIDTH-2:0], mosiLvl};
          bitCnt_d  = bitCnt_q + CNT_W'(1);
          if (bitCnt_q == CNT_LAST) begin
            rxData_d  = {rxShift_q[WIDTH-2:0], mosiLvl};
            rxValid_d = 1'b1;
            state_d   = HOLD;
          end
        end else if (sclkFall) begin
          txShift_d = {txShift_q[WIDTH-2:0], 1'b0};
        end
      end
      HOLD: begin
        if (csRise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A load in the frame-start cycle lands after the underrun decision, so the word waits for the next frame.
    if (tx_valid && !txBufFull_q) begin
      txBuf_d     = tx_data;
      txBufFull_d = 1'b1;
    end
  end

  assign miso_oe     = (state_q != IDLE);
  assign miso        = miso_oe & txShift_q[WIDTH-1];
  assign tx_ready    = ~txBufFull_q;
  assign rx_data     = rxData_q;
  assign rx_valid    = rxValid_q;
  assign rx_abort    = rxAbort_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Self-checking bench for spi_slave_xcvr: a behavioural mode-0 SPI master,
// a table of directed frames and hand-written corner-case sequences.
module tb_spi_slave_xcvr;

  localparam int W    = 12;
  localparam int HALF = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sclk = 1'b0;
  logic         cs = 1'b1;
  logic         mosi = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         miso, miso_oe, tx_ready, rx_valid, rx_abort, tx_underrun;
  logic [W-1:0] rx_data;

  int vecCount = 0;
  int failCount = 0;
  int rvCnt = 0, abCnt = 0, urCnt = 0, bothCnt = 0, oeCnt = 0;

  typedef struct {
    bit           preload;
    logic [W-1:0] txWord;
    logic [W-1:0] mosiWord;
    logic [W-1:0] expRx;
    logic [W-1:0] expMiso;
    int           expUnderrun;
  } vec_t;

  vec_t vecs[5];

  spi_slave_xcvr #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_abort(rx_abort), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  // Count strobe cycles away from the active edge so pulse widths and counts can be checked.
  always @(negedge clk) begin
    if (rx_valid) rvCnt++;
    if (rx_abort) abCnt++;
    if (tx_underrun) urCnt++;
    if (rx_valid && rx_abort) bothCnt++;
    if (miso_oe) oeCnt++;
  end

  // Give up on a hung run with a reported failure.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic loadTx(input logic [W-1:0] word);
    int n = 0;
    while (!tx_ready && n < 50) begin
      waitClk(1);
      n++;
    end
    checkOutput("tx_ready before load", tx_ready, 1);
    tx_data  = word;
    tx_valid = 1'b1;
    waitClk(1);
    tx_valid = 1'b0;
  endtask

  // Behavioural SPI master: mode 0, MSB first, optional extra sclk pulses after the word.
  task automatic applyStimulus(input logic [W-1:0] mosiWord, input int nbits, input int extra,
                               input bit coincident, input logic [W-1:0] coinWord, input bit keepCs,
                               output logic [W-1:0] masterRx, output logic readyMid, output logic oeMid);
    masterRx = '0;
    cs   = 1'b0;
    mosi = mosiWord[W-1];
    if (coincident) begin
      waitClk(2);
      tx_data  = coinWord;
      tx_valid = 1'b1;
      waitClk(1);
      tx_valid = 1'b0;
      waitClk(HALF - 3);
    end else begin
      waitClk(HALF);
    end
    readyMid = tx_ready;
    oeMid    = miso_oe;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      masterRx = {masterRx[W-2:0], miso};
      waitClk(HALF);
      sclk = 1'b0;
      if (i < W - 1) mosi = mosiWord[W-2-i];
      waitClk(HALF);
    end
    for (int i = 0; i < extra; i++) begin
      sclk = 1'b1;
      waitClk(HALF);
      sclk = 1'b0;
      waitClk(HALF);
    end
    if (!keepCs) cs = 1'b1;
    mosi = 1'b0;
  endtask

  initial begin
    logic [W-1:0] got;
    logic         rdy, oe;
    int           rv0, ab0, ur0, oe0;
    logic [W-1:0] b2b[3];

    vecs[0] = '{1'b1, 12'hA5C, 12'd791, 12'd791, 12'hA5C, 0};
    vecs[1] = '{1'b1, 12'h123, 12'hABC, 12'hABC, 12'h123, 0};
    vecs[2] = '{1'b0, 12'h000, 12'h5A5, 12'h5A5, 12'h000, 1};
    vecs[3] = '{1'b1, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 0};
    vecs[4] = '{1'b1, 12'h801, 12'h7FE, 12'h7FE, 12'h801, 0};
    b2b[0] = 12'h001;
    b2b[1] = 12'h800;
    b2b[2] = 12'hFFF;

    // Reset with random pin activity
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cs       = 1'($urandom_range(0, 1));
      sclk     = 1'($urandom_range(0, 1));
      mosi     = 1'($urandom_range(0, 1));
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = W'($urandom);
      waitClk(1);
    end
    checkOutput("reset miso", miso, 0);
    checkOutput("reset miso_oe", miso_oe, 0);
    checkOutput("reset rx_data", rx_data, 0);
    checkOutput("reset rx_valid", rx_valid, 0);
    checkOutput("reset rx_abort", rx_abort, 0);
    checkOutput("reset tx_underrun", tx_underrun, 0);
    checkOutput("reset tx_ready", tx_ready, 1);

    // Release with cs low and clock some sclk pulses: must stay idle
    tx_valid = 1'b0;
    cs = 1'b0; sclk = 1'b0; mosi = 1'b0;
    waitClk(1);
    reset = 1'b1;
    oe0 = oeCnt; rv0 = rvCnt;
    for (int k = 0; k < 4; k++) begin
      sclk = 1'b1; waitClk(HALF);
      sclk = 1'b0; waitClk(HALF);
    end
    checkOutput("cs low at release: no miso_oe", oeCnt - oe0, 0);
    checkOutput("cs low at release: no rx_valid", rvCnt - rv0, 0);
    cs = 1'b1;
    waitClk(6);

    // Table-driven full frames
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].preload) loadTx(vecs[i].txWord);
      rv0 = rvCnt; ur0 = urCnt; ab0 = abCnt;
      applyStimulus(vecs[i].mosiWord, W, 0, 1'b0, '0, 1'b0, got, rdy, oe);
      waitClk(8);
      checkOutput($sformatf("vec%0d rx_data", i), rx_data, vecs[i].expRx);
      checkOutput($sformatf("vec%0d master rx", i), got, vecs[i].expMiso);
      checkOutput($sformatf("vec%0d rx_valid cycles", i), rvCnt - rv0, 1);
      checkOutput($sformatf("vec%0d underrun", i), urCnt - ur0, vecs[i].expUnderrun);
      checkOutput($sformatf("vec%0d abort", i), abCnt - ab0, 0);
      checkOutput($sformatf("vec%0d tx_ready after start", i), rdy, 1);
      checkOutput($sformatf("vec%0d miso_oe in frame", i), oe, 1);
      checkOutput($sformatf("vec%0d miso_oe after", i), miso_oe, 0);
    end

    // Abort after 5 bits
    loadTx(12'h3C3);
    rv0 = rvCnt; ab0 = abCnt;
    applyStimulus(12'hFFF, 5, 0, 1'b0, '0, 1'b0, got, rdy, oe);
    waitClk(8);
    checkOutput("abort pulses", abCnt - ab0, 1);
    checkOutput("abort no rx_valid", rvCnt - rv0, 0);
    checkOutput("abort rx_data kept", rx_data, 12'h7FE);
    checkOutput("abort miso_oe after", miso_oe, 0);
    loadTx(12'h6D6);
    rv0 = rvCnt;
    applyStimulus(12'h2B4, W, 0, 1'b0, '0, 1'b0, got, rdy, oe);
    waitClk(8);
    checkOutput("post-abort rx_data", rx_data, 12'h2B4);
    checkOutput("post-abort master rx", got, 12'h6D6);
    checkOutput("post-abort rx_valid", rvCnt - rv0, 1);

    // Underrun with a load in the frame-start cycle
    ur0 = urCnt;
    applyStimulus(12'h0F0, W, 0, 1'b1, 12'h9E7, 1'b0, got, rdy, oe);
    waitClk(8);
    checkOutput("coincident underrun", urCnt - ur0, 1);
    checkOutput("coincident master rx", got, 12'h000);
    checkOutput("coincident rx_data", rx_data, 12'h0F0);
    checkOutput("coincident word buffered", tx_ready, 0);
    ur0 = urCnt;
    applyStimulus(12'h111, W, 0, 1'b0, '0, 1'b0, got, rdy, oe);
    waitClk(8);
    checkOutput("buffered word returned", got, 12'h9E7);
    checkOutput("buffered frame no underrun", urCnt - ur0, 0);
    checkOutput("buffered frame rx_data", rx_data, 12'h111);

    // Back-to-back frames, minimum cs-high gap, extra sclk pulses in HOLD
    for (int i = 0; i < 3; i++) begin
      rv0 = rvCnt;
      applyStimulus(b2b[i], W, 2, 1'b0, '0, 1'b0, got, rdy, oe);
      checkOutput($sformatf("b2b%0d rx_data", i), rx_data, b2b[i]);
      checkOutput($sformatf("b2b%0d rx_valid", i), rvCnt - rv0, 1);
      waitClk(4);
    end
    waitClk(8);
    checkOutput("b2b final rx_data", rx_data, 12'hFFF);

    // Reset in the middle of a frame
    loadTx(12'h456);
    applyStimulus(12'hA5A, 6, 0, 1'b0, '0, 1'b1, got, rdy, oe);
    loadTx(12'h777);
    checkOutput("mid-frame miso_oe before reset", miso_oe, 1);
    reset = 1'b0;
    #2;
    checkOutput("mid-frame reset miso_oe", miso_oe, 0);
    checkOutput("mid-frame reset miso", miso, 0);
    checkOutput("mid-frame reset rx_data", rx_data, 0);
    checkOutput("mid-frame reset tx_ready", tx_ready, 1);
    waitClk(2);
    reset = 1'b1;
    oe0 = oeCnt;
    waitClk(10);
    checkOutput("post-reset frame ignored", oeCnt - oe0, 0);
    cs = 1'b1;
    waitClk(6);
    loadTx(12'hC3A);
    rv0 = rvCnt;
    applyStimulus(12'h1E1, W, 0, 1'b0, '0, 1'b0, got, rdy, oe);
    waitClk(8);
    checkOutput("post-reset rx_data", rx_data, 12'h1E1);
    checkOutput("post-reset master rx", got, 12'hC3A);
    checkOutput("post-reset rx_valid", rvCnt - rv0, 1);

    checkOutput("rx_valid with rx_abort", bothCnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
